// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dmem_arbiter                                                 |
// | Description : Round-robin arbiter sharing one data memory between two CPU  |
// |               cache ports; one registered transaction in flight at a time. |
// |               Optional BUSY timeout enabled by DMEM_ARB_TIMEOUT_EN.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dmem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int LINE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] u_addr_0,
  input  logic              u_re_0,
  input  logic              u_we_0,
  input  logic [LINE_W-1:0] u_wdata_0,
  output logic [LINE_W-1:0] u_rd_data_0,
  output logic              u_rdy_0,
  input  logic [ADDR_W-1:0] u_addr_1,
  input  logic              u_re_1,
  input  logic              u_we_1,
  input  logic [LINE_W-1:0] u_wdata_1,
  output logic [LINE_W-1:0] u_rd_data_1,
  output logic              u_rdy_1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              grant_0,
  output logic              grant_1
`ifdef DMEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_rr_ptr, r_owner;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_re, r_mem_we;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              r_grant_0, r_grant_1, r_rdy_0, r_rdy_1;
  logic [LINE_W-1:0] r_rd_data_0, r_rd_data_1;
  logic              w_act_0, w_act_1, w_gnt_vld, w_gnt_idx, w_gnt_we;
  logic              w_done, w_to_hit;
  logic [LINE_W-1:0] w_rsp_data;

  // A simultaneous re+we is treated as a write.
  assign w_act_0  = u_re_0 | u_we_0;
  assign w_act_1  = u_re_1 | u_we_1;
  assign w_gnt_we = w_gnt_idx ? u_we_1 : u_we_0;

`ifdef DMEM_ARB_TIMEOUT_EN
  logic [9:0] r_to_cnt;
  logic       r_timeout_err;

  assign w_to_hit   = (r_state == ST_BUSY) && !mem_rdy && (r_to_cnt == 10'd1023);
  assign w_rsp_data = w_to_hit ? {LINE_W{1'b1}} : mem_rdata;
  assign timeout_err = r_timeout_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_gnt_vld)
        r_to_cnt <= '0;
      else if (r_state == ST_BUSY)
        r_to_cnt <= r_to_cnt + 10'd1;
      if (w_to_hit)
        r_timeout_err <= 1'b1;
    end
  end
`else
  assign w_to_hit   = 1'b0;
  assign w_rsp_data = mem_rdata;
`endif

  assign w_done = (r_state == ST_BUSY) && (mem_rdy || w_to_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_act_0 && w_act_1) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = r_rr_ptr;
        end else if (w_act_0 || w_act_1) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_act_1;
        end
        if (w_gnt_vld)
          w_state_nxt = ST_BUSY;
      end
      ST_BUSY: if (w_done) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_re    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_grant_0   <= 1'b0;
      r_grant_1   <= 1'b0;
      r_rdy_0     <= 1'b0;
      r_rdy_1     <= 1'b0;
      r_rd_data_0 <= '0;
      r_rd_data_1 <= '0;
    end else begin
      r_rdy_0 <= 1'b0;
      r_rdy_1 <= 1'b0;
      if (w_gnt_vld) begin
        r_owner     <= w_gnt_idx;
        r_rr_ptr    <= ~w_gnt_idx;
        r_mem_addr  <= w_gnt_idx ? u_addr_1 : u_addr_0;
        r_mem_wdata <= w_gnt_idx ? u_wdata_1 : u_wdata_0;
        r_mem_we    <= w_gnt_we;
        r_mem_re    <= ~w_gnt_we;
        r_grant_0   <= ~w_gnt_idx;
        r_grant_1   <= w_gnt_idx;
      end
      if (w_done) begin
        r_mem_re <= 1'b0;
        r_mem_we <= 1'b0;
        if (r_owner) begin
          r_rdy_1 <= 1'b1;
          if (r_mem_re || w_to_hit) r_rd_data_1 <= w_rsp_data;
        end else begin
          r_rdy_0 <= 1'b1;
          if (r_mem_re || w_to_hit) r_rd_data_0 <= w_rsp_data;
        end
      end
      if (r_state == ST_DONE) begin
        r_grant_0 <= 1'b0;
        r_grant_1 <= 1'b0;
      end
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign mem_wdata   = r_mem_wdata;
  assign grant_0     = r_grant_0;
  assign grant_1     = r_grant_1;
  assign u_rdy_0     = r_rdy_0;
  assign u_rdy_1     = r_rdy_1;
  assign u_rd_data_0 = r_rd_data_0;
  assign u_rd_data_1 = r_rd_data_1;

endmodule
`default_nettype wire
